// File: rtl/uart_script_pkg.sv
// Shared types and helpers for the UART script player.
package uart_script_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESENT   = 3'd1,
        S_GAP       = 3'd2,
        S_WAIT_RESP = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    // Carriage return, the usual end-of-reply marker.
    localparam byte_t CR = 8'h0D;

    // Address width that stays at least one bit for single-entry memories.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_script_resp_buf.sv
// Response capture buffer: appends bytes until full, flags dropped bytes
// as a sticky overflow, and offers an asynchronous read port.
module uart_script_resp_buf
    import uart_script_pkg::*;
#(
    parameter int RESP_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clr,
    input  logic                              we,
    input  logic [7:0]                        din,
    input  logic [addr_w(RESP_DEPTH)-1:0]     rd_addr,
    output logic [7:0]                        rd_data,
    output logic [$clog2(RESP_DEPTH+1)-1:0]   count,
    output logic                              full,
    output logic                              overflow
);

    localparam int RAW = addr_w(RESP_DEPTH);
    localparam int CW  = $clog2(RESP_DEPTH + 1);

    byte_t           buf_q [RESP_DEPTH];
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            overflow_q;
    logic            overflow_d;
    logic            full_s;

    assign full_s   = (count_q == CW'(RESP_DEPTH));
    assign full     = full_s;
    assign count    = count_q;
    assign overflow = overflow_q;

    // Next fill level and sticky overflow: a clear wins, then a write either lands or is dropped.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clr) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (we) begin
            if (full_s) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Fill level and overflow flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Byte storage; contents are left alone by reset, only the count matters.
    always_ff @(posedge clk) begin
        if (we && !full_s && !clr) begin
            buf_q[count_q[RAW-1:0]] <= din;
        end
    end

    // Asynchronous read, returning zero for addresses past the buffer.
    always_comb begin
        if (int'(rd_addr) < RESP_DEPTH) begin
            rd_data = buf_q[rd_addr];
        end else begin
            rd_data = 8'h00;
        end
    end

endmodule

// File: rtl/uart_script_player.sv
// UART script player: replays a stored byte script into a transmitter
// controller with a fixed inter-byte gap, then captures the reply up to a
// terminator byte. Optional response-wait timeout is enabled by defining
// UART_SCRIPT_PLAYER_TIMEOUT_EN.
module uart_script_player
    import uart_script_pkg::*;
#(
    parameter int          DEPTH      = 32,
    parameter int          RESP_DEPTH = 16,
    parameter int          GAP        = 10000,
    parameter logic [7:0]  TERM       = CR,
    parameter int          TIMEOUT    = 1000000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [addr_w(DEPTH)-1:0]          wr_addr,
    input  logic [7:0]                        wr_data,
    input  logic                              start,
    input  logic [$clog2(DEPTH+1)-1:0]        len,
    output logic [7:0]                        tx_dout,
    output logic                              tx_empty,
    input  logic                              tx_re,
    input  logic [7:0]                        rx_din,
    input  logic                              rx_we,
    output logic                              rx_full,
    input  logic [addr_w(RESP_DEPTH)-1:0]     resp_rd_addr,
    output logic [7:0]                        resp_rd_data,
    output logic [$clog2(RESP_DEPTH+1)-1:0]   resp_count,
    output logic                              busy,
    output logic                              done,
    output logic                              overflow,
    output logic                              timeout
);

    localparam int AW    = addr_w(DEPTH);
    localparam int LW    = $clog2(DEPTH + 1);
    // One counter serves both the gap and the response timeout.
    localparam int CNT_W = $clog2(max_i(GAP, TIMEOUT) + 2);

    byte_t             mem_q [DEPTH];
    state_t            state_q, state_d;
    logic [LW-1:0]     idx_q, idx_d;
    logic [LW-1:0]     len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic              tx_empty_q, tx_empty_d;
    byte_t             tx_dout_q, tx_dout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              start_ok_s;
    logic              pop_s;
    logic              cap_en_s;
    logic              term_s;
    logic [LW-1:0]     eff_len_s;

    assign start_ok_s = start && (state_q == S_IDLE);
    assign pop_s      = (state_q == S_PRESENT) && tx_re;
    assign cap_en_s   = rx_we && (state_q != S_IDLE);
    // A terminator ends the wait whether it was stored or dropped.
    assign term_s     = cap_en_s && (rx_din == TERM);
    assign eff_len_s  = (int'(len) > DEPTH) ? LW'(DEPTH) : len;

    assign tx_dout  = tx_dout_q;
    assign tx_empty = tx_empty_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign timeout  = timeout_q;

    uart_script_resp_buf #(
        .RESP_DEPTH (RESP_DEPTH)
    ) u_resp_buf (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_ok_s),
        .we       (cap_en_s),
        .din      (rx_din),
        .rd_addr  (resp_rd_addr),
        .rd_data  (resp_rd_data),
        .count    (resp_count),
        .full     (rx_full),
        .overflow (overflow)
    );

    // Script memory is writable only while idle and is never cleared.
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == S_IDLE) && (int'(wr_addr) < DEPTH)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // State, sequencing and registered output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
            tx_empty_q <= 1'b1;
            tx_dout_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
            tx_empty_q <= tx_empty_d;
            tx_dout_q  <= tx_dout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic: start, byte pops, gap timing and end-of-reply detection.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    timeout_d = 1'b0;
                    idx_d     = '0;
                    cnt_d     = '0;
                    if (len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PRESENT;
                        len_d   = eff_len_s;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRESENT: begin
                if (pop_s) begin
                    idx_d = idx_q + LW'(1);
                    cnt_d = '0;
                    if ((idx_q + LW'(1)) == len_q) begin
                        state_d = S_WAIT_RESP;
                    end else if (GAP == 0) begin
                        state_d = S_PRESENT;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    state_d = S_PRESENT;
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP - 1)) begin
                    state_d = S_PRESENT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_RESP: begin
                if (term_s) begin
                    state_d = S_DONE;
                end else begin
`ifdef UART_SCRIPT_PLAYER_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`else
                    state_d = S_WAIT_RESP;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        tx_empty_d = 1'b1;
        tx_dout_d  = 8'h00;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        if (state_d == S_PRESENT) begin
            tx_empty_d = 1'b0;
            tx_dout_d  = mem_q[idx_d[AW-1:0]];
        end else begin
            tx_empty_d = 1'b1;
            tx_dout_d  = 8'h00;
        end
    end

endmodule

// File: tb/tb_uart_script_player.sv
// Self-checking bench for uart_script_player: transmitted bytes and pop
// spacing go through a scoreboard queue; status is checked directly.
module tb_uart_script_player;
    import uart_script_pkg::*;

    localparam int DEPTH      = 32;
    localparam int RESP_DEPTH = 4;
    localparam int GAP        = 10;
    localparam int TIMEOUT    = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        start;
    logic [5:0]  len;
    logic [7:0]  tx_dout;
    logic        tx_empty;
    logic        tx_re;
    logic [7:0]  rx_din;
    logic        rx_we;
    logic        rx_full;
    logic [1:0]  resp_rd_addr;
    logic [7:0]  resp_rd_data;
    logic [2:0]  resp_count;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        timeout;

    uart_script_player #(
        .DEPTH      (DEPTH),
        .RESP_DEPTH (RESP_DEPTH),
        .GAP        (GAP),
        .TERM       (8'h0D),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .start        (start),
        .len          (len),
        .tx_dout      (tx_dout),
        .tx_empty     (tx_empty),
        .tx_re        (tx_re),
        .rx_din       (rx_din),
        .rx_we        (rx_we),
        .rx_full      (rx_full),
        .resp_rd_addr (resp_rd_addr),
        .resp_rd_data (resp_rd_data),
        .resp_count   (resp_count),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    byte_t exp_tx[$];
    bit    first_pop = 1'b1;
    int    last_pop  = 0;

    logic [7:0] script [14] = '{8'h36, 8'h20, 8'h32, 8'h20, 8'h2B, 8'h20, 8'h33,
                                8'h20, 8'h31, 8'h20, 8'h2D, 8'h20, 8'h2A, 8'h0D};

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: a pop is pending whenever tx_re meets a non-empty output.
    always @(negedge clk) begin
        byte_t e;
        if (!rst && tx_re && !tx_empty) begin
            checks++;
            if (exp_tx.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pop got %02h expected no pop", tx_dout);
            end else begin
                e = exp_tx.pop_front();
                if (tx_dout !== e) begin
                    errors++;
                    $display("FAIL tx_byte got %02h expected %02h", tx_dout, e);
                end
            end
            if (!first_pop) begin
                checks++;
                if (cyc - last_pop != GAP + 1) begin
                    errors++;
                    $display("FAIL pop_spacing got %0d expected %0d", cyc - last_pop, GAP + 1);
                end
            end
            first_pop = 1'b0;
            last_pop  = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input int addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = 5'(addr);
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    // Queue the expected bytes, then pulse start for one cycle.
    task automatic start_run(input int l, input int n_push);
        for (int i = 0; i < n_push; i++) exp_tx.push_back(script[i]);
        first_pop = 1'b1;
        start = 1'b1;
        len   = 6'(l);
        tick();
        start = 1'b0;
    endtask

    // Wait for the scoreboard to empty; returns on the last pop edge.
    task automatic drain(input int budget);
        int k = 0;
        while (exp_tx.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if (exp_tx.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d left expected 0", exp_tx.size());
            exp_tx.delete();
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_we  = 1'b1;
        rx_din = b;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_done;
        logic [7:0] exp_resp [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
        rst = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 8'h00;
        start = 1'b0; len = 6'd0; tx_re = 1'b1; rx_din = 8'h00; rx_we = 1'b0;
        resp_rd_addr = 2'd0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_tx_empty", tx_empty, 1);
        chk("rst_tx_dout", tx_dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_resp_count", resp_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_rx_full", rx_full, 0);
        tick();
        rst = 1'b0;
        tick();

        // len=0: straight to DONE
        start = 1'b1; len = 6'd0;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 1);
        chk("len0_tx_empty", tx_empty, 1);
        chk("len0_resp_count", resp_count, 0);
        @(negedge clk);
        chk("len0_done_fall", done, 0);
        chk("len0_busy_fall", busy, 0);

        // Load script
        tick();
        for (int i = 0; i < 14; i++) write_mem(i, script[i]);

        // Full script replay with an ignored second start
        start_run(14, 14);
        repeat (2) tick();
        start = 1'b1; len = 6'd3;
        tick();
        start = 1'b0;
        drain(14 * (GAP + 1) + 40);
        #1;
        @(negedge clk);
        chk("wait_busy", busy, 1);
        chk("wait_tx_empty", tx_empty, 1);
        chk("wait_done", done, 0);
        repeat (5) tick();

        // Reply 1 6 CR
        send_rx(8'h31);
        send_rx(8'h36);
        send_rx(8'h0D);
        rx_we = 1'b0;
        @(negedge clk);
        chk("resp_done", done, 1);
        chk("resp_count", resp_count, 3);
        @(negedge clk);
        chk("resp_done_fall", done, 0);
        chk("resp_busy_fall", busy, 0);
        chk("resp_rx_full", rx_full, 0);
        chk("resp_overflow", overflow, 0);
        resp_rd_addr = 2'd0; #1; chk("resp_rd0", resp_rd_data, 8'h31);
        resp_rd_addr = 2'd1; #1; chk("resp_rd1", resp_rd_data, 8'h36);
        resp_rd_addr = 2'd2; #1; chk("resp_rd2", resp_rd_data, 8'h0D);

        // Overflow: six reply bytes into a four-byte buffer
        tick();
        start_run(1, 1);
        @(negedge clk);
        chk("ovf_count_cleared", resp_count, 0);
        drain(20);
        #1;
        send_rx(8'h41);
        send_rx(8'h42);
        send_rx(8'h43);
        send_rx(8'h44);
        send_rx(8'h45);
        send_rx(8'h0D);
        rx_we = 1'b0;
        @(negedge clk);
        chk("ovf_done", done, 1);
        chk("ovf_count", resp_count, 4);
        chk("ovf_rx_full", rx_full, 1);
        chk("ovf_overflow", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            resp_rd_addr = 2'(i);
            #1;
            chk("ovf_rd", resp_rd_data, 32'(exp_resp[i]));
        end
        tick();

        // Reset during the gap after byte 3, then replay from the start
        start_run(14, 3);
        drain(3 * (GAP + 1) + 20);
        #1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_tx_empty", tx_empty, 1);
        chk("abort_busy", busy, 0);
        repeat (30) tick();
        start_run(2, 2);
        drain(2 * (GAP + 1) + 20);
        #1;
        @(negedge clk);
        chk("replay_busy", busy, 1);
        tick();
        send_rx(8'h0D);
        rx_we = 1'b0;
        @(negedge clk);
        chk("replay_done", done, 1);
        chk("replay_count", resp_count, 1);
        tick();

        // No reply: timeout or indefinite wait depending on build
        start_run(1, 1);
        drain(20);
        first_done = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done && first_done < 0) first_done = k;
        end
`ifdef UART_SCRIPT_PLAYER_TIMEOUT_EN
        chk("to_done_cycle", 32'(first_done), 32'(TIMEOUT));
        chk("to_flag", timeout, 1);
        chk("to_busy", busy, 0);
`else
        chk("nto_no_done", 32'(first_done), 32'hFFFF_FFFF);
        chk("nto_busy", busy, 1);
        chk("nto_flag", timeout, 0);
        #1;
        send_rx(8'h0D);
        rx_we = 1'b0;
        @(negedge clk);
        chk("nto_done", done, 1);
`endif
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_script_player.md
Name: uart_script_player

Overview:
- Synthesizable, parametrised UART script sequencer.
- Replays a stored byte script (e.g. "6 2 + 3 1 - *\r") into a UART transmitter controller through its din/empty/re interface, with a programmable inter-character gap.
- Captures the DUT's reply from a UART receiver controller (din/we/full) into a response buffer.
- Used in bench and on-board self-test around the RPN calculator top.

Parameters:
- DEPTH, 32: script memory depth in bytes.
- RESP_DEPTH, 16: response buffer depth in bytes.
- GAP, 10000: idle cycles between a byte pop and the next byte being presented.
- TERM, 8'h0D: response terminator byte.
- TIMEOUT, 1000000: response-wait limit in cycles. Used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  script memory write strobe
- wr_addr  in  $clog2(DEPTH)  script write address
- wr_data  in  8  script write data
- start  in  1  start pulse
- len  in  $clog2(DEPTH+1)  number of script bytes to send
- tx_dout  out  8  byte to transmitter controller din
- tx_empty  out  1  low = byte available
- tx_re  in  1  transmitter pop
- rx_din  in  8  byte from receiver controller
- rx_we  in  1  receiver write strobe
- rx_full  out  1  response buffer full (to receiver full)
- resp_rd_addr  in  $clog2(RESP_DEPTH)  response read address
- resp_rd_data  out  8  combinational read of response buffer
- resp_count  out  $clog2(RESP_DEPTH+1)  bytes captured
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- overflow  out  1  sticky: a byte was dropped because the buffer was full
- timeout  out  1  sticky: response timed out (optional feature; tied 0 when absent)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; tx_dout=0, tx_empty=1, busy=0, done=0, resp_count=0, overflow=0, timeout=0, rx_full=0. The script memory is not cleared. Reset mid-operation aborts at the next edge with no further pops.
- FSM states: IDLE, PRESENT, GAP, WAIT_RESP, DONE.
- IDLE:
  - wr_en writes mem[wr_addr]. wr_en is ignored in every other state.
  - start with len=0 → DONE.
  - start with len>0 → PRESENT, and in the same edge: clear resp_count, overflow and timeout; byte index=0; effective length = min(len, DEPTH).
  - start outside IDLE is ignored.
- PRESENT:
  - tx_empty=0 and tx_dout=mem[idx], starting the cycle after start.
  - Pop occurs when tx_re=1 while tx_empty=0. On pop, idx increments.
  - If more bytes remain → GAP. If the popped byte was the last → WAIT_RESP (no trailing gap).
  - tx_re while tx_empty=1 is ignored.
- GAP:
  - tx_empty=1. Counter runs GAP cycles, then → PRESENT.
  - The next byte is visible exactly GAP+1 cycles after the pop edge.
  - GAP=0 presents the next byte the cycle after the pop.
- WAIT_RESP: leaves to DONE the cycle after a captured rx_din==TERM, or after a TERM dropped while the buffer is full.
- DONE: done=1 for one cycle, then → IDLE. resp_count, overflow and timeout hold until the next accepted start.
- Capture (every state except IDLE):
  - rx_we with resp_count<RESP_DEPTH: store at index resp_count, resp_count+1. TERM is stored.
  - rx_we with the buffer full: byte dropped, overflow=1.
  - rx_full = (resp_count==RESP_DEPTH).
  - Bytes arriving during PRESENT/GAP (echo) are captured normally.
- Simultaneous pop and rx_we in one cycle: both take effect.

Optional Feature:
- Macro UART_SCRIPT_PLAYER_TIMEOUT_EN.
- Defined: a cycle counter runs in WAIT_RESP. On reaching TIMEOUT without TERM, set timeout=1 and → DONE.
- Undefined: WAIT_RESP waits indefinitely, timeout is tied 0, and the TIMEOUT parameter is unused.

Decomposition:
- Package uart_script_pkg: byte_t (8-bit), state enum, CR constant 8'h0D.
- One sub-module, uart_script_resp_buf: response buffer with write, count, full, overflow and combinational read port, parametrised by RESP_DEPTH.
- Script memory and FSM stay in the top module.

Test Plan:
- Load "6 2 + 3 1 - *\r" (14 bytes), GAP=10, tx_re asserted every cycle tx_empty=0, len=14, start → tx_dout sequence 0x36,0x20,0x32,…,0x0D. Successive pops are exactly 11 cycles apart. WAIT_RESP entered after the 0x0D pop.
- In WAIT_RESP, rx bytes 0x31,0x36,0x0D → resp_count=3, resp_rd_data[0..2]=0x31,0x36,0x0D. done pulses one cycle after the 0x0D capture, and busy falls with it.
- RESP_DEPTH=4, six rx bytes ending in 0x0D → resp_count=4, rx_full=1, overflow=1, done asserted.
- start with len=0 → done one cycle later. tx_empty stays 1 and resp_count=0. A second start while busy has no effect.
- Assert rst during GAP after byte 3 → next edge: tx_empty=1, busy=0, no further pops. A new start replays from mem[0].
- With UART_SCRIPT_PLAYER_TIMEOUT_EN and TIMEOUT=50, no rx bytes → timeout=1 and done exactly 50 cycles after WAIT_RESP is entered. Without the macro, busy stays 1 beyond 50 cycles.
